multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
Multi-cycle sequencer for the RISC-V CPU. It replaces single-cycle decode with a state machine that steps each instruction through fetch, decode, execute, memory and writeback over several clocks, sharing one memory port between instruction fetch and data access through a req/ack handshake. It supports R-type, I-type ALU, load (lw), store (sw) and branch (beq/bne). It traps on illegal opcodes and on memory-ack timeouts.

Parameters:
TIMEOUT_CYCLES, 16, consecutive cycles with mem_req=1 and mem_ack=0 before a bus-error trap; legal range 1..255.
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous, active-high reset.
opcode  input  7  instruction[6:0] from IR; valid from DECODE onward.
funct3  input  3  instruction[14:12] from IR.
zero  input  1  ALU zero flag, i.e. rs1==rs2 compare result.
mem_ack  input  1  memory completes the current request this cycle.
mem_req  output  1  memory request; held high until mem_ack.
mem_we  output  1  1=write (store), 0=read.
iord  output  1  memory address select: 0=PC, 1=ALU result register.
ir_write  output  1  load IR from memory read data.
pc_write  output  1  update PC.
pc_src  output  1  0=PC+4, 1=branch target.
reg_write  output  1  register file write enable.
mem_to_reg  output  1  writeback select: 1=memory data register, 0=ALU result register.
alu_src  output  1  ALU B operand: 1=immediate, 0=rs2.
alu_op  output  2  00=add (load/store), 01=sub (branch), 10=R-type funct decode, 11=I-type funct decode.
instr_retired  output  1  one-cycle pulse when an instruction completes.
instr_count  output  CNT_W  count of retired instructions; wraps modulo 2^CNT_W.
illegal_op  output  1  sticky; set on an unsupported opcode.
bus_err  output  1  sticky; set on a memory timeout.
state_dbg  output  4  current state encoding, for debug.

Behaviour:
- Clocking: one clock; reset is synchronous and active-high.
- Reset (rst sampled high): state=FETCH; instr_count=0; illegal_op=0; bus_err=0; timeout counter=0. While rst=1, all strobe outputs are forced to 0 (mem_req, mem_we, ir_write, pc_write, reg_write, instr_retired). A reset mid-instruction aborts it with no writes; FETCH begins on the first cycle after rst falls.
- State encodings: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, MEM_ADDR=4, MEM_RD=5, MEM_WR=6, WB_ALU=7, WB_MEM=8, BRANCH=9, TRAP=15.
- FETCH: mem_req=1, iord=0, mem_we=0. In the cycle mem_ack=1: ir_write=1, pc_write=1, pc_src=0, next state DECODE. Otherwise stay in FETCH.
- DECODE: latch opcode and funct3 into internal registers; later input changes are ignored until the next DECODE. Transitions:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 or 0100011 -> MEM_ADDR
  - 1100011 -> BRANCH
  - any other opcode -> TRAP, with illegal_op set.
- EXEC_R: alu_op=10, alu_src=0 -> WB_ALU.
- EXEC_I: alu_op=11, alu_src=1 -> WB_ALU.
- WB_ALU: reg_write=1, mem_to_reg=0, instr_retired=1 -> FETCH.
- MEM_ADDR: alu_op=00, alu_src=1. Next state is MEM_RD for a load, MEM_WR for a store.
- MEM_RD: mem_req=1, iord=1, mem_we=0. Stay until mem_ack, then -> WB_MEM.
- WB_MEM: reg_write=1, mem_to_reg=1, instr_retired=1 -> FETCH.
- MEM_WR: mem_req=1, iord=1, mem_we=1. On mem_ack: instr_retired=1 -> FETCH.
- BRANCH: alu_op=01, alu_src=0. Branch is taken when (funct3=000 & zero) | (funct3=001 & ~zero). If taken: pc_write=1, pc_src=1. Any other funct3 is not taken (no trap). instr_retired=1 -> FETCH.
- Latency with zero-wait memory (ack in the same cycle as req): R/I=4 cycles, load=5, store=4, branch=3.
- Outputs not listed for a state are 0.
- mem_req, once raised, stays high with a stable address select and mem_we until mem_ack.
- Timeout:
  - The counter increments each cycle that mem_req=1 and mem_ack=0, and clears on mem_ack or on leaving a wait state.
  - When the count reaches TIMEOUT_CYCLES (ack still low), the next state is TRAP and bus_err is set. No ir_write, pc_write or reg_write occurs.
  - An ack arriving in the same cycle the count would reach the limit wins: normal completion, no trap.
- TRAP: all strobes 0; stays in TRAP until rst.
- instr_count increments exactly on instr_retired cycles; rolls over from all-ones to 0.

Test Plan:
- R-type, ack tied high: rst 2 cycles, opcode=0110011 -> states 0,1,2,7,0; ir_write and pc_write in cycle 1; reg_write=1, mem_to_reg=0 in cycle 4; instr_count=1.
- Load with 3 wait cycles on data read: opcode=0000011 -> MEM_RD holds mem_req=1, iord=1, mem_we=0 for 4 cycles; then WB_MEM with reg_write=1, mem_to_reg=1.
- Store: opcode=0100011 -> MEM_WR asserts mem_we=1, iord=1; reg_write stays 0 throughout; instr_retired pulses on the ack cycle.
- Branch: funct3=000, zero=1 -> pc_write=1, pc_src=1 in BRANCH. funct3=001, zero=1 -> pc_write=0. Both cases take 3 cycles total.
- Illegal opcode 1111111 -> TRAP (state_dbg=15), illegal_op=1, all strobes 0 for 10+ cycles; rst then returns state to FETCH with illegal_op=0.
- Timeout and mid-op reset: TIMEOUT_CYCLES=16, mem_ack=0 in FETCH -> bus_err=1 and TRAP after 16 cycles. Separately, rst in MEM_RD -> no reg_write, state=FETCH, instr_count=0.

Source files
------------

// File: rtl/multicycle_control_fsm_if.sv
// rtl/multicycle_control_fsm_if.sv - shared memory port handshake between the sequencer and memory
// Purpose: one memory port shared by instruction fetch and data access.
// Signals:
//   mem_req - request, held high until mem_ack
//   mem_we  - 1=write (store), 0=read
//   iord    - address select: 0=PC, 1=ALU result register
//   mem_ack - memory completes the current request this cycle
interface multicycle_control_fsm_if;
  logic mem_req;
  logic mem_we;
  logic iord;
  logic mem_ack;

  modport master (output mem_req, output mem_we, output iord, input mem_ack);
  modport slave  (input mem_req, input mem_we, input iord, output mem_ack);
endinterface

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multi-cycle RISC-V control sequencer with trap handling
// Purpose: steps each instruction through fetch/decode/execute/memory/writeback,
//   sharing one memory port, trapping on illegal opcodes and memory timeouts.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   mem (master)        - shared memory req/ack port
//   opcode, funct3      - instruction fields from IR
//   zero                - ALU compare result (rs1==rs2)
//   ir_write, pc_write, pc_src, reg_write, mem_to_reg, alu_src, alu_op - datapath controls
//   instr_retired       - one-cycle completion pulse
//   instr_count         - retired-instruction counter (wraps)
//   illegal_op, bus_err - sticky trap causes
//   state_dbg           - current state encoding
module multicycle_control_fsm #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  multicycle_control_fsm_if.master       mem,
  input  logic [6:0]                     opcode,
  input  logic [2:0]                     funct3,
  input  logic                           zero,
  output logic                           ir_write,
  output logic                           pc_write,
  output logic                           pc_src,
  output logic                           reg_write,
  output logic                           mem_to_reg,
  output logic                           alu_src,
  output logic [1:0]                     alu_op,
  output logic                           instr_retired,
  output logic [CNT_W-1:0]               instr_count,
  output logic                           illegal_op,
  output logic                           bus_err,
  output logic [3:0]                     state_dbg
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_I   = 4'd3,
    MEM_ADDR = 4'd4,
    MEM_RD   = 4'd5,
    MEM_WR   = 4'd6,
    WB_ALU   = 4'd7,
    WB_MEM   = 4'd8,
    BRANCH   = 4'd9,
    TRAP     = 4'd15
  } state_e;

  // Value of the wait counter on the last cycle before a timeout trap.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic             is_store_q, is_store_d;
  logic [2:0]       f3_q, f3_d;
  logic [7:0]       tmo_q, tmo_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             illegal_q, illegal_d;
  logic             bus_err_q, bus_err_d;

  logic req_c, we_c, iord_c, ir_c, pcw_c, pcs_c, rw_c, m2r_c, asrc_c, ret_c;
  logic [1:0] aop_c;
  logic taken;

  assign taken = ((f3_q == 3'b000) && zero) || ((f3_q == 3'b001) && !zero);

  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    f3_d       = f3_q;
    tmo_d      = '0;
    count_d    = count_q;
    illegal_d  = illegal_q;
    bus_err_d  = bus_err_q;
    req_c  = 1'b0;
    we_c   = 1'b0;
    iord_c = 1'b0;
    ir_c   = 1'b0;
    pcw_c  = 1'b0;
    pcs_c  = 1'b0;
    rw_c   = 1'b0;
    m2r_c  = 1'b0;
    asrc_c = 1'b0;
    aop_c  = 2'b00;
    ret_c  = 1'b0;

    case (state_q)
      FETCH: begin
        req_c = 1'b1;
        if (mem.mem_ack) begin
          ir_c    = 1'b1;
          pcw_c   = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        // Only the load/store distinction and funct3 are needed later.
        is_store_d = (opcode == 7'b0100011);
        f3_d       = funct3;
        case (opcode)
          7'b0110011:             state_d = EXEC_R;
          7'b0010011:             state_d = EXEC_I;
          7'b0000011, 7'b0100011: state_d = MEM_ADDR;
          7'b1100011:             state_d = BRANCH;
          default: begin
            state_d   = TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      EXEC_R: begin
        aop_c   = 2'b10;
        state_d = WB_ALU;
      end
      EXEC_I: begin
        aop_c   = 2'b11;
        asrc_c  = 1'b1;
        state_d = WB_ALU;
      end
      WB_ALU: begin
        rw_c    = 1'b1;
        ret_c   = 1'b1;
        state_d = FETCH;
      end
      MEM_ADDR: begin
        asrc_c  = 1'b1;
        state_d = is_store_q ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        req_c  = 1'b1;
        iord_c = 1'b1;
        if (mem.mem_ack) state_d = WB_MEM;
      end
      WB_MEM: begin
        rw_c    = 1'b1;
        m2r_c   = 1'b1;
        ret_c   = 1'b1;
        state_d = FETCH;
      end
      MEM_WR: begin
        req_c  = 1'b1;
        iord_c = 1'b1;
        we_c   = 1'b1;
        if (mem.mem_ack) begin
          ret_c   = 1'b1;
          state_d = FETCH;
        end
      end
      BRANCH: begin
        aop_c   = 2'b01;
        pcw_c   = taken;
        pcs_c   = taken;
        ret_c   = 1'b1;
        state_d = FETCH;
      end
      default: state_d = TRAP;
    endcase

    // Timeout: an ack on the limit cycle takes the normal path above, and
    // the write strobes are already gated by ack, so trapping here is clean.
    if (req_c && !mem.mem_ack) begin
      if (tmo_q == TMO_LAST) begin
        state_d   = TRAP;
        bus_err_d = 1'b1;
      end else begin
        tmo_d = tmo_q + 8'd1;
      end
    end

    if (ret_c) count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH;
      is_store_q <= 1'b0;
      f3_q       <= 3'b000;
      tmo_q      <= '0;
      count_q    <= '0;
      illegal_q  <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
      f3_q       <= f3_d;
      tmo_q      <= tmo_d;
      count_q    <= count_d;
      illegal_q  <= illegal_d;
      bus_err_q  <= bus_err_d;
    end
  end

  // Strobes are held low while reset is asserted so an aborted instruction
  // cannot write anything.
  assign mem.mem_req    = req_c & ~rst;
  assign mem.mem_we     = we_c & ~rst;
  assign mem.iord       = iord_c;
  assign ir_write       = ir_c & ~rst;
  assign pc_write       = pcw_c & ~rst;
  assign pc_src         = pcs_c;
  assign reg_write      = rw_c & ~rst;
  assign mem_to_reg     = m2r_c;
  assign alu_src        = asrc_c;
  assign alu_op         = aop_c;
  assign instr_retired  = ret_c & ~rst;
  assign instr_count    = count_q;
  assign illegal_op     = illegal_q;
  assign bus_err        = bus_err_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - directed self-checking bench for multicycle_control_fsm
module tb_multicycle_control_fsm;
  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        zero;
  logic        ir_write, pc_write, pc_src, reg_write, mem_to_reg, alu_src;
  logic [1:0]  alu_op;
  logic        instr_retired;
  logic [31:0] instr_count;
  logic        illegal_op, bus_err;
  logic [3:0]  state_dbg;
  int          errors = 0;
  int          checks = 0;

  multicycle_control_fsm_if bus ();

  multicycle_control_fsm #(.TIMEOUT_CYCLES(16), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .mem(bus.master),
    .opcode(opcode), .funct3(funct3), .zero(zero),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .alu_src(alu_src),
    .alu_op(alu_op), .instr_retired(instr_retired), .instr_count(instr_count),
    .illegal_op(illegal_op), .bus_err(bus_err), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [5:0] strobes();
    return {bus.mem_req, bus.mem_we, ir_write, pc_write, reg_write, instr_retired};
  endfunction

  initial begin
    rst = 1'b1; bus.mem_ack = 1'b1; opcode = 7'b0110011; funct3 = 3'b000; zero = 1'b0;
    nxt(); nxt();
    chk("rst_state", 32'(state_dbg), 32'd0);
    chk("rst_strobes", 32'(strobes()), 32'd0);
    chk("rst_count", instr_count, 32'd0);
    chk("rst_flags", {30'd0, illegal_op, bus_err}, 32'd0);

    // R-type with zero-wait memory: 0,1,2,7,0
    @(negedge clk); rst = 1'b0; #1;
    chk("r_fetch_state", 32'(state_dbg), 32'd0);
    chk("r_fetch_ctl", {26'd0, bus.mem_req, bus.iord, bus.mem_we, ir_write, pc_write, pc_src}, 32'b100110);
    nxt(); chk("r_decode", 32'(state_dbg), 32'd1);
    nxt(); chk("r_exec", {26'd0, state_dbg, alu_op}, {26'd0, 4'd2, 2'b10});
    chk("r_exec_src", 32'(alu_src), 32'd0);
    nxt(); chk("r_wb_state", 32'(state_dbg), 32'd7);
    chk("r_wb_ctl", {29'd0, reg_write, mem_to_reg, instr_retired}, 32'b101);
    nxt(); chk("r_done", 32'(state_dbg), 32'd0);
    chk("r_count", instr_count, 32'd1);

    // Load with 3 wait cycles on the data read
    opcode = 7'b0000011;
    nxt(); chk("ld_decode", 32'(state_dbg), 32'd1);
    nxt(); chk("ld_addr", {26'd0, state_dbg, alu_op}, {26'd0, 4'd4, 2'b00});
    chk("ld_addr_src", 32'(alu_src), 32'd1);
    bus.mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nxt();
      chk("ld_wait", {27'd0, state_dbg, bus.mem_req}, {27'd0, 4'd5, 1'b1});
      chk("ld_wait_ctl", {29'd0, bus.iord, bus.mem_we, reg_write}, 32'b100);
    end
    nxt(); bus.mem_ack = 1'b1; #1;
    chk("ld_ack", {26'd0, state_dbg, bus.mem_req, bus.iord}, {26'd0, 4'd5, 2'b11});
    nxt(); chk("ld_wb_state", 32'(state_dbg), 32'd8);
    chk("ld_wb_ctl", {29'd0, reg_write, mem_to_reg, instr_retired}, 32'b111);
    nxt(); chk("ld_count", instr_count, 32'd2);

    // Store
    opcode = 7'b0100011;
    chk("st_fetch_rw", 32'(reg_write), 32'd0);
    nxt(); chk("st_dec_rw", 32'(reg_write), 32'd0);
    nxt(); chk("st_addr", {27'd0, state_dbg, reg_write}, {27'd0, 4'd4, 1'b0});
    nxt(); chk("st_wr_state", 32'(state_dbg), 32'd6);
    chk("st_wr_ctl", {27'd0, bus.mem_req, bus.mem_we, bus.iord, reg_write, instr_retired}, 32'b11101);
    nxt(); chk("st_done", 32'(state_dbg), 32'd0);
    chk("st_count", instr_count, 32'd3);

    // beq taken
    opcode = 7'b1100011; funct3 = 3'b000; zero = 1'b1;
    nxt(); nxt();
    chk("beq_state", 32'(state_dbg), 32'd9);
    chk("beq_ctl", {27'd0, pc_write, pc_src, alu_op, instr_retired}, 32'b11011);
    nxt(); chk("beq_done", 32'(state_dbg), 32'd0);

    // bne not taken (zero=1)
    funct3 = 3'b001;
    nxt(); nxt();
    chk("bne_nt_state", 32'(state_dbg), 32'd9);
    chk("bne_nt_ctl", {29'd0, pc_write, pc_src, instr_retired}, 32'b001);
    nxt(); chk("bne_count", instr_count, 32'd5);

    // bne taken (zero=0)
    zero = 1'b0;
    nxt(); nxt();
    chk("bne_t_ctl", {29'd0, pc_write, pc_src, instr_retired}, 32'b111);
    nxt();

    // I-type
    opcode = 7'b0010011;
    nxt(); nxt();
    chk("i_exec", {25'd0, state_dbg, alu_op, alu_src}, {25'd0, 4'd3, 2'b11, 1'b1});
    nxt(); chk("i_wb", 32'(state_dbg), 32'd7);
    nxt(); chk("i_count", instr_count, 32'd7);

    // Illegal opcode traps until reset
    opcode = 7'b1111111;
    nxt(); nxt();
    chk("ill_state", 32'(state_dbg), 32'd15);
    chk("ill_flag", 32'(illegal_op), 32'd1);
    for (int i = 0; i < 10; i++) begin
      nxt();
      chk("ill_hold", {22'd0, state_dbg, strobes()}, {22'd0, 4'd15, 6'd0});
    end
    @(negedge clk); rst = 1'b1; opcode = 7'b0110011; #1;
    nxt();
    chk("ill_rst", {26'd0, state_dbg, illegal_op, bus_err}, {26'd0, 4'd0, 2'b00});
    chk("ill_rst_count", instr_count, 32'd0);

    // Fetch timeout: 16 unacknowledged cycles trap
    bus.mem_ack = 1'b0;
    @(negedge clk); rst = 1'b0; #1;
    for (int i = 0; i < 15; i++) begin
      nxt();
      chk("tmo_wait", {27'd0, state_dbg, bus_err}, {27'd0, 4'd0, 1'b0});
    end
    nxt();
    chk("tmo_trap", {27'd0, state_dbg, bus_err}, {27'd0, 4'd15, 1'b1});
    chk("tmo_strobes", 32'(strobes()), 32'd0);

    // Reset in the middle of a load: no writes, back to FETCH
    @(negedge clk); rst = 1'b1; #1;
    nxt(); rst = 1'b0; bus.mem_ack = 1'b1; opcode = 7'b0000011;
    nxt(); nxt();
    bus.mem_ack = 1'b0;
    nxt(); chk("mid_in_rd", 32'(state_dbg), 32'd5);
    @(negedge clk); rst = 1'b1; bus.mem_ack = 1'b1; #1;
    chk("mid_rst_strobes", 32'(strobes()), 32'd0);
    nxt();
    chk("mid_rst_state", 32'(state_dbg), 32'd0);
    chk("mid_rst_count", instr_count, 32'd0);

    // Ack on the limit cycle wins over the timeout
    bus.mem_ack = 1'b0;
    @(negedge clk); rst = 1'b0; #1;
    for (int i = 0; i < 15; i++) nxt();
    chk("race_pre", 32'(state_dbg), 32'd0);
    bus.mem_ack = 1'b1; #1;
    chk("race_irw", 32'(ir_write), 32'd1);
    nxt();
    chk("race_state", {27'd0, state_dbg, bus_err}, {27'd0, 4'd1, 1'b0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
